// File: rtl/wb_port_arbiter_if.sv
// Writeback request / register-file write bundle shared by the arbiter and its requesters.
// Latency: none (wires only).
// Backpressure: req_ready_o per requester; write side has no backpressure.
// Ports (signals):
//   req_valid_i/req_addr_i/req_data_i : requester -> arbiter
//   req_ready_o                        : arbiter -> requester, combinational accept
//   w_en_o/w_addr_o/w_data_o           : arbiter -> register file, two write ports
interface wb_port_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int REQ_NUM    = 4
);
  logic [REQ_NUM-1:0]                 req_valid_i;
  logic [REQ_NUM-1:0][4:0]            req_addr_i;
  logic [REQ_NUM-1:0][DATA_WIDTH-1:0] req_data_i;
  logic [REQ_NUM-1:0]                 req_ready_o;
  logic [1:0]                         w_en_o;
  logic [1:0][4:0]                    w_addr_o;
  logic [1:0][DATA_WIDTH-1:0]         w_data_o;

  // Arbiter side.
  modport slave (
    input  req_valid_i, req_addr_i, req_data_i,
    output req_ready_o, w_en_o, w_addr_o, w_data_o
  );

  // Requester / register-file side.
  modport master (
    output req_valid_i, req_addr_i, req_data_i,
    input  req_ready_o, w_en_o, w_addr_o, w_data_o
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Writeback arbiter: shares two register-file write ports among REQ_NUM requesters, rotating priority.
// Latency: accept in cycle N (combinational ready), registered write visible on w_* in cycle N+1.
// Backpressure: req_ready_o low holds a requester; r0 writes are always accepted and dropped.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : wb_port_arbiter_if.slave (requests in, ready out, register-file write ports out)
module wb_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int REQ_NUM    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  wb_port_arbiter_if.slave   bus
);

  localparam int IDX_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

  logic [IDX_W-1:0]           ptr_q, ptr_d;
  logic [1:0]                 w_en_q;
  logic [1:0][4:0]            w_addr_q;
  logic [1:0][DATA_WIDTH-1:0] w_data_q;

  logic [REQ_NUM-1:0] rdy;
  logic               s0_vld, s1_vld;
  logic [IDX_W-1:0]   s0_idx, s1_idx, cand_idx, last_idx;
  int                 pos;

  // Grant selection. Slot 0 is the first non-r0 candidate from ptr; slot 1 is
  // the next one whose address differs from slot 0, so a same-register loser
  // simply waits while a later requester may still use port 1.
  always_comb begin
    rdy      = '0;
    s0_vld   = 1'b0;
    s1_vld   = 1'b0;
    s0_idx   = '0;
    s1_idx   = '0;
    cand_idx = '0;
    pos      = 0;

    for (int i = 0; i < REQ_NUM; i++) begin
      if (bus.req_valid_i[i] && (bus.req_addr_i[i] == 5'd0)) begin
        rdy[i] = 1'b1;
      end
    end

    for (int k = 0; k < REQ_NUM; k++) begin
      pos = int'(ptr_q) + k;
      if (pos >= REQ_NUM) begin
        pos = pos - REQ_NUM;
      end
      cand_idx = IDX_W'(pos);
      if (bus.req_valid_i[cand_idx] && (bus.req_addr_i[cand_idx] != 5'd0)) begin
        if (!s0_vld) begin
          s0_vld = 1'b1;
          s0_idx = cand_idx;
        end else if (!s1_vld && (bus.req_addr_i[cand_idx] != bus.req_addr_i[s0_idx])) begin
          s1_vld = 1'b1;
          s1_idx = cand_idx;
        end
      end
    end

    if (s0_vld) begin
      rdy[s0_idx] = 1'b1;
    end
    if (s1_vld) begin
      rdy[s1_idx] = 1'b1;
    end
  end

  // Priority restarts just past the last port winner.
  always_comb begin
    last_idx = s1_vld ? s1_idx : s0_idx;
    if (last_idx == IDX_W'(REQ_NUM - 1)) begin
      ptr_d = '0;
    end else begin
      ptr_d = last_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q    <= '0;
      w_en_q   <= '0;
      w_addr_q <= '0;
      w_data_q <= '0;
    end else begin
      w_en_q <= {s1_vld, s0_vld};
      // Address/data hold when a port is idle; only the enable drops.
      if (s0_vld) begin
        w_addr_q[0] <= bus.req_addr_i[s0_idx];
        w_data_q[0] <= bus.req_data_i[s0_idx];
        ptr_q       <= ptr_d;
      end
      if (s1_vld) begin
        w_addr_q[1] <= bus.req_addr_i[s1_idx];
        w_data_q[1] <= bus.req_data_i[s1_idx];
      end
    end
  end

  assign bus.req_ready_o = rdy;
  assign bus.w_en_o      = w_en_q;
  assign bus.w_addr_o    = w_addr_q;
  assign bus.w_data_o    = w_data_q;

endmodule
